// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Parametrised pipeline stage register with a valid/ready handshake.
//   A 2-entry skid buffer (main + skid) keeps in_ready a function of a flop
//   and the flush input only, so no combinational ready path crosses the
//   stage. The control payload is forced to zero whenever an entry slot is
//   empty, so a squashed or drained instruction can never write state
//   downstream.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous squash of every held entry
//   in_valid   in   upstream offers an entry
//   in_ready   out  stage can accept (= no skid entry and no flush)
//   in_data    in   upstream data payload   [DATA_W]
//   in_ctrl    in   upstream control payload [CTRL_W]
//   out_valid  out  main entry valid (registered)
//   out_ready  in   downstream accepts
//   out_data   out  main register data       [DATA_W]
//   out_ctrl   out  main register control, 0 when out_valid=0 [CTRL_W]
//   occupancy  out  entries held, 0..2 (registered)
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int DATA_W        = 96,
  parameter int CTRL_W        = 16,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // State bits are {m_valid, s_valid}; 2'b01 would break the invariant
  // that a skid entry implies a main entry and is never produced.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [1:0]        occ_q, occ_d;

  logic acc;
  logic drn;

  // Value a data slot takes when its entry goes away: cleared when
  // ZERO_ON_FLUSH is set, otherwise left as-is to avoid toggling.
  function automatic logic [DATA_W-1:0] data_on_empty(input logic [DATA_W-1:0] held);
    logic [DATA_W-1:0] res;
    if (ZERO_ON_FLUSH) begin
      res = {DATA_W{1'b0}};
    end else begin
      res = held;
    end
    return res;
  endfunction

  // Number of valid entries encoded by a state value.
  function automatic logic [1:0] entries_of(input state_e st);
    return {1'b0, st[1]} + {1'b0, st[0]};
  endfunction

  assign in_ready  = !state_q[0] && !flush;
  assign out_valid = state_q[1];
  assign out_data  = m_data_q;
  assign out_ctrl  = m_ctrl_q;
  assign occupancy = occ_q;

  assign acc = in_valid && in_ready;
  assign drn = state_q[1] && out_ready;

  // Next-state and next-payload computation; inputs are only sampled on acc,
  // so garbage on in_data/in_ctrl never reaches the registers otherwise.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (flush) begin
      // A same-cycle drain was already seen downstream; everything goes.
      state_d  = ST_EMPTY;
      m_ctrl_d = {CTRL_W{1'b0}};
      s_ctrl_d = {CTRL_W{1'b0}};
      m_data_d = data_on_empty(m_data_q);
      s_data_d = data_on_empty(s_data_q);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d  = ST_ONE;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (acc && drn) begin
            state_d  = ST_ONE;
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (acc) begin
            // Downstream stalled: park the new entry behind main.
            state_d  = ST_FULL;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
          end else if (drn) begin
            state_d  = ST_EMPTY;
            m_ctrl_d = {CTRL_W{1'b0}};
            m_data_d = data_on_empty(m_data_q);
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (drn) begin
            state_d  = ST_ONE;
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            s_ctrl_d = {CTRL_W{1'b0}};
            s_data_d = data_on_empty(s_data_q);
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          m_ctrl_d = {CTRL_W{1'b0}};
          s_ctrl_d = {CTRL_W{1'b0}};
          m_data_d = {DATA_W{1'b0}};
          s_data_d = {DATA_W{1'b0}};
        end
      endcase
    end

    occ_d = entries_of(state_d);
  end

  // State, payload and occupancy registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      m_data_q <= {DATA_W{1'b0}};
      m_ctrl_q <= {CTRL_W{1'b0}};
      s_data_q <= {DATA_W{1'b0}};
      s_ctrl_q <= {CTRL_W{1'b0}};
      occ_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

  localparam int DW = 96;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;

  logic          in_ready_a, out_valid_a;
  logic [DW-1:0] out_data_a;
  logic [CW-1:0] out_ctrl_a;
  logic [1:0]    occ_a;

  logic          in_ready_b, out_valid_b;
  logic [DW-1:0] out_data_b;
  logic [CW-1:0] out_ctrl_b;
  logic [1:0]    occ_b;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .ZERO_ON_FLUSH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_ctrl(out_ctrl_a), .occupancy(occ_a)
  );

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .ZERO_ON_FLUSH(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_ctrl(out_ctrl_b), .occupancy(occ_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One directed cycle: inputs, in_ready before the edge, outputs after it.
  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [7:0]  d;
    logic [15:0] c;
    logic        exp_ir;
    logic        exp_ov;
    logic [7:0]  exp_d;
    logic [15:0] exp_c;
    logic [1:0]  exp_occ;
    logic [7:0]  exp_db;   // out_data of the hold-data instance
  } vec_t;

  vec_t vecs[12];

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t q[$];

  initial begin
    ent_t    popped;
    logic    m_ir;
    logic [DW-1:0] exp_d;
    logic [CW-1:0] exp_c;

    //            iv    ordy  fl    d      c         ir    ov    od     oc        occ   odb
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h10, 16'h0010, 1'b1, 1'b1, 8'h10, 16'h0010, 2'd1, 8'h10};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 16'h0011, 1'b1, 1'b1, 8'h10, 16'h0010, 2'd2, 8'h10};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h12, 16'h0012, 1'b0, 1'b1, 8'h10, 16'h0010, 2'd2, 8'h10};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h12, 16'h0012, 1'b0, 1'b1, 8'h11, 16'h0011, 2'd1, 8'h11};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h12, 16'h0012, 1'b1, 1'b1, 8'h12, 16'h0012, 2'd1, 8'h12};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0, 8'h12};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h20, 16'h8001, 1'b1, 1'b1, 8'h20, 16'h8001, 2'd1, 8'h20};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0, 8'h20};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h30, 16'hFFFF, 1'b1, 1'b1, 8'h30, 16'hFFFF, 2'd1, 8'h30};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h31, 16'hFFFF, 1'b1, 1'b1, 8'h30, 16'hFFFF, 2'd2, 8'h30};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h32, 16'hFFFF, 1'b0, 1'b0, 8'h00, 16'h0000, 2'd0, 8'h30};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 2'd0, 8'h30};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;

    // Reset state
    #12;
    chk("rst_ov", {127'd0, out_valid_a}, 128'd0);
    chk("rst_oc", {112'd0, out_ctrl_a}, 128'd0);
    chk("rst_od", {32'd0, out_data_a}, 128'd0);
    chk("rst_occ", {126'd0, occ_a}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ir", {127'd0, in_ready_a}, 128'd1);

    // Directed table: backpressure/skid, bubble ctrl zero, flush in FULL
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      in_data   = {88'd0, vecs[i].d};
      in_ctrl   = vecs[i].c;
      @(negedge clk);
      chk($sformatf("vec%0d_ir_a", i), {127'd0, in_ready_a}, {127'd0, vecs[i].exp_ir});
      chk($sformatf("vec%0d_ir_b", i), {127'd0, in_ready_b}, {127'd0, vecs[i].exp_ir});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ov", i), {127'd0, out_valid_a}, {127'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_od", i), {32'd0, out_data_a}, {120'd0, vecs[i].exp_d});
      chk($sformatf("vec%0d_oc", i), {112'd0, out_ctrl_a}, {112'd0, vecs[i].exp_c});
      chk($sformatf("vec%0d_occ", i), {126'd0, occ_a}, {126'd0, vecs[i].exp_occ});
      chk($sformatf("vec%0d_od_b", i), {32'd0, out_data_b}, {120'd0, vecs[i].exp_db});
      chk($sformatf("vec%0d_oc_b", i), {112'd0, out_ctrl_b}, {112'd0, vecs[i].exp_c});
    end
    flush = 1'b0;

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_data = DW'(i); in_ctrl = CW'(i);
      @(negedge clk);
      chk($sformatf("stream%0d_ir", i), {127'd0, in_ready_a}, 128'd1);
      @(posedge clk); #1;
      chk($sformatf("stream%0d_od", i), {32'd0, out_data_a}, 128'(i));
      chk($sformatf("stream%0d_ov", i), {127'd0, out_valid_a}, 128'd1);
      chk($sformatf("stream%0d_occ", i), {126'd0, occ_a}, 128'd1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_end_occ", {126'd0, occ_a}, 128'd0);

    // Reset asserted asynchronously while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hA1; in_ctrl = 16'h00A1;
    @(posedge clk); #1;
    in_data = 96'hA2; in_ctrl = 16'h00A2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rfull_occ_before", {126'd0, occ_a}, 128'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rfull_ov", {127'd0, out_valid_a}, 128'd0);
    chk("rfull_oc", {112'd0, out_ctrl_a}, 128'd0);
    chk("rfull_occ", {126'd0, occ_a}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rfull_ir_after", {127'd0, in_ready_a}, 128'd1);
    chk("rfull_ov_after", {127'd0, out_valid_a}, 128'd0);

    // Random traffic against a FIFO scoreboard
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_data   = {$urandom(), $urandom(), $urandom()};
      in_ctrl   = CW'($urandom());
      @(negedge clk);
      m_ir = (q.size() < 2) && !flush;
      exp_d = (q.size() > 0) ? q[0].d : '0;
      exp_c = (q.size() > 0) ? q[0].c : '0;
      chk("rnd_ir_a", {127'd0, in_ready_a}, {127'd0, m_ir});
      chk("rnd_ir_b", {127'd0, in_ready_b}, {127'd0, m_ir});
      chk("rnd_ov_a", {127'd0, out_valid_a}, {127'd0, q.size() > 0});
      chk("rnd_ov_b", {127'd0, out_valid_b}, {127'd0, q.size() > 0});
      chk("rnd_oc_a", {112'd0, out_ctrl_a}, {112'd0, exp_c});
      chk("rnd_oc_b", {112'd0, out_ctrl_b}, {112'd0, exp_c});
      chk("rnd_od_a", {32'd0, out_data_a}, {32'd0, exp_d});
      if (q.size() > 0) begin
        chk("rnd_od_b", {32'd0, out_data_b}, {32'd0, exp_d});
      end
      chk("rnd_occ_a", {126'd0, occ_a}, 128'(q.size()));
      chk("rnd_occ_b", {126'd0, occ_b}, 128'(q.size()));
      chk("rnd_skid_implies_main", {127'd0, (occ_a != 2'd2) || out_valid_a}, 128'd1);
      chk("rnd_occ_le2", {127'd0, occ_a <= 2'd2}, 128'd1);
      @(posedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (out_ready && q.size() > 0) begin
          popped = q.pop_front();
        end
        if (in_valid && m_ir) begin
          q.push_back('{d: in_data, c: in_ctrl});
        end
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised, general-purpose pipeline stage register; successor to the fixed-field ID/EX-style stall/flush registers.
- Replaces global stall/flush wiring with a valid/ready handshake per stage, backed by a 2-entry skid buffer so that `in_ready` is fully registered.
- Bundles separate data and control fields.
- Control bits are forced to zero on any bubble, so a squashed instruction can never write state downstream.

Parameters:
- DATA_W, 96, width of datapath payload (operands, PC, immediate).
- CTRL_W, 16, width of control payload (opcode, reg_wr, mem_wr, ...); zeroed on every bubble.
- ZERO_ON_FLUSH, 1, 1 = data fields also cleared on flush/drain-to-empty; 0 = data holds last value (power saving).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  stage can accept; = !skid_valid && !flush.
- in_data  input  DATA_W  upstream data payload.
- in_ctrl  input  CTRL_W  upstream control payload.
- out_valid  output  1  main entry valid; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main register data.
- out_ctrl  output  CTRL_W  main register control; 0 when out_valid=0.
- occupancy  output  2  entries held, 0..2.

Behaviour:
- **Storage:** main {m_valid, m_data, m_ctrl} and skid {s_valid, s_data, s_ctrl}. Invariant: s_valid implies m_valid.
- **Handshakes:**
  - acc = in_valid && in_ready.
  - drn = m_valid && out_ready.
  - `out_valid` = m_valid, `out_data` = m_data, `out_ctrl` = m_ctrl, directly from registers; no combinational in→out path.
- **States**, encoded by (m_valid, s_valid):
  - EMPTY(0,0): acc → main<=in, ONE. Otherwise stay.
  - ONE(1,0):
    - acc&&drn → main<=in, ONE.
    - acc&&!drn → skid<=in, FULL.
    - !acc&&drn → EMPTY; m_ctrl<=0, and m_data<=0 if ZERO_ON_FLUSH.
    - neither → hold.
  - FULL(1,1): in_ready=0. drn → main<=skid, skid cleared (s_ctrl<=0), ONE. Otherwise hold.
- **Latency and throughput:**
  - 1 cycle from accept into EMPTY/ONE-with-drain to out_valid.
  - Sustained throughput 1 entry/cycle with out_ready=1.
  - `in_ready` deasserts the cycle after entering FULL (registered via s_valid).
- **Flush** (highest priority below reset):
  - Next state EMPTY; m_ctrl, s_ctrl <= 0.
  - Data <= 0 if ZERO_ON_FLUSH, else hold.
  - in_ready forced 0, so no accept that cycle.
  - A drain in the same cycle still counts for downstream (out_valid was 1), but the entry is gone next cycle.
- **Reset** (asynchronous, any state, mid-transfer included):
  - m_valid=0, s_valid=0.
  - out_data=0, out_ctrl=0, s_data=0, s_ctrl=0.
  - occupancy=0.
  - in_ready goes to 1 after reset release.
- **Order:** strict FIFO; skid entry always leaves after main. No reordering, no duplication, no drop except on flush.
- **Occupancy:** m_valid + s_valid, registered.
- **Unknown inputs:** in_data/in_ctrl are ignored when !acc; X on them must not propagate into registers.

Test Plan:
- **Reset mid-FULL:** fill with 0xA1, 0xA2 (out_ready=0), assert rst_n=0 asynchronously → out_valid=0, out_ctrl=0, occupancy=0 before next clk edge; in_ready=1 after release.
- **Streaming:** out_ready=1, in_valid=1 for 8 cycles, data 1..8 → out_data 1..8 on consecutive cycles starting 1 cycle after the first accept; occupancy stays 1; in_ready stays 1.
- **Backpressure/skid:** send 0x10, 0x11 with out_ready=0 → occupancy=2, in_ready=0 next cycle. Raise out_ready for 2 cycles → outputs 0x10 then 0x11, no loss. in_valid held with 0x12 during the stall is accepted only after in_ready returns.
- **Flush in FULL:** ctrl=0xFFFF entries held, flush=1 with in_valid=1 → in_ready=0 that cycle, next cycle out_valid=0, out_ctrl=0, occupancy=0, and no entry captured. With ZERO_ON_FLUSH=0, out_data retains the old value.
- **Bubble control zero:** single entry ctrl=0x8001 drains with no new input → next cycle out_valid=0, out_ctrl=0x0000.
- **Random:** 10k cycles of random in_valid/out_ready/flush against a scoreboard FIFO model → zero mismatches. Check invariant s_valid→m_valid every cycle, and occupancy ≤ 2.
